// File: rtl/pipeline_pkg.sv
// Shared types for the five-stage pipeline: forwarding selects, stage controls,
// ALU op codes and the forwarding-source priority rule.
package pipeline_pkg;

  typedef enum logic [1:0] {FWD_REG, FWD_WB, FWD_MEM} fwd_sel_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       branch;
    logic [3:0] alucontrol;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // MEM is the younger producer, so it wins over WB; $0 never forwards.
  function automatic fwd_sel_t fwd_pick(input logic [4:0] src,
                                        input logic rw_m, input logic [4:0] wr_m,
                                        input logic rw_w, input logic [4:0] wr_w);
    if (src != 5'd0 && rw_m && wr_m == src) return FWD_MEM;
    if (src != 5'd0 && rw_w && wr_w == src) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection: EX operand forwarding, load-use stall,
// and flushes for a taken branch (EX) or a jump (ID).
module hazard_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       takenE,
  input  logic       jumpD,
  output fwd_sel_t   fwdA,
  output fwd_sel_t   fwdB,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE
);
  logic lwstall;

  assign fwdA = fwd_pick(rsE, regwriteM, writeregM, regwriteW, writeregW);
  assign fwdB = fwd_pick(rtE, regwriteM, writeregM, regwriteW, writeregW);

  assign lwstall = memtoregE && rtE != 5'd0 && (rtE == rsD || rtE == rtD);

  // A taken branch squashes everything younger, so it cancels the stall.
  assign stallF = lwstall && !takenE;
  assign stallD = stallF;
  // A jump waits in ID while a load-use stall is pending.
  assign flushD = takenE || (jumpD && !lwstall);
  assign flushE = takenE || lwstall;

endmodule

// File: rtl/pipelined_datapath.sv
// Five-stage MIPS datapath (IF/ID/EX/MEM/WB) with EX forwarding, load-use
// stall, branch resolved in EX and jump resolved in ID.
module pipelined_datapath
  import pipeline_pkg::*;
#(
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [N-1:0]  pc,
  input  logic [31:0]   instr,
  output logic [31:0]   instrD,
  input  logic          regwriteD,
  input  logic          memtoregD,
  input  logic          memwriteD,
  input  logic          alusrcD,
  input  logic          regdstD,
  input  logic          branchD,
  input  logic          jumpD,
  input  logic [3:0]    alucontrolD,
  output logic          memwriteM,
  output logic [N-1:0]  aluoutM,
  output logic [N-1:0]  writedataM,
  input  logic [N-1:0]  readdataM,
  output logic          stallF,
  output logic          flushE
);
  // Stage records carry N-wide data, so they are typed here where N is known.
  typedef struct packed {
    logic [31:0]  instr;
    logic [N-1:0] pcplus4;
  } if_id_t;
  typedef struct packed {
    ctrl_t        ctrl;
    logic [N-1:0] rd1, rd2, signimm, pcplus4;
    logic [4:0]   rs, rt, rd;
  } id_ex_t;
  typedef struct packed {
    logic         regwrite, memtoreg, memwrite;
    logic [N-1:0] aluout, writedata;
    logic [4:0]   writereg;
  } ex_mem_t;
  typedef struct packed {
    logic         regwrite, memtoreg;
    logic [N-1:0] aluout, readdata;
    logic [4:0]   writereg;
  } mem_wb_t;

  localparam if_id_t  IF_ID_BUBBLE  = '0;
  localparam id_ex_t  ID_EX_BUBBLE  = '0;
  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  if_id_t  fd;
  id_ex_t  de, de_next;
  ex_mem_t em;
  mem_wb_t mw;
  ctrl_t   ctrlD;

  logic [N-1:0] rf [32];
  logic [N-1:0] pcplus4F, pc_next, pcjumpD, pcbranchE;
  logic [N-1:0] rd1D, rd2D, signimmD, resultW;
  logic [N-1:0] srcaE, srcbE, wdataE, aluoutE;
  logic [4:0]   rsD, rtD, rdD, writeregE;
  logic         zeroE, takenE, stallD, flushD;
  fwd_sel_t     fwdA, fwdB;

  // ---------------- IF ----------------
  assign pcplus4F = pc + {{(N-3){1'b0}}, 3'd4};

  always_comb begin
    pc_next = pcplus4F;
    if (takenE)      pc_next = pcbranchE;
    else if (flushD) pc_next = pcjumpD;   // without takenE, flushD means a jump is leaving ID
    else if (stallF) pc_next = pc;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;

  always_ff @(posedge clk or posedge reset)
    if (reset)        fd <= IF_ID_BUBBLE;
    else if (flushD)  fd <= IF_ID_BUBBLE;
    else if (!stallD) fd <= '{instr: instr, pcplus4: pcplus4F};

  // ---------------- ID ----------------
  assign instrD   = fd.instr;
  assign rsD      = fd.instr[25:21];
  assign rtD      = fd.instr[20:16];
  assign rdD      = fd.instr[15:11];
  assign signimmD = {{(N-16){fd.instr[15]}}, fd.instr[15:0]};
  assign pcjumpD  = {fd.pcplus4[N-1:28], fd.instr[25:0], 2'b00};

  assign rd1D = (mw.regwrite && mw.writereg != 5'd0 && mw.writereg == rsD) ? resultW : rf[rsD];
  assign rd2D = (mw.regwrite && mw.writereg != 5'd0 && mw.writereg == rtD) ? resultW : rf[rtD];

  assign ctrlD = '{regwrite: regwriteD, memtoreg: memtoregD, memwrite: memwriteD,
                   alusrc: alusrcD, regdst: regdstD, branch: branchD, alucontrol: alucontrolD};
  assign de_next = '{ctrl: ctrlD, rd1: rd1D, rd2: rd2D, signimm: signimmD,
                     pcplus4: fd.pcplus4, rs: rsD, rt: rtD, rd: rdD};

  always_ff @(posedge clk or posedge reset)
    if (reset)       de <= ID_EX_BUBBLE;
    else if (flushE) de <= ID_EX_BUBBLE;
    else             de <= de_next;

  // ---------------- EX ----------------
  always_comb begin
    case (fwdA)
      FWD_MEM: srcaE = em.aluout;
      FWD_WB:  srcaE = resultW;
      default: srcaE = de.rd1;
    endcase
    case (fwdB)
      FWD_MEM: wdataE = em.aluout;
      FWD_WB:  wdataE = resultW;
      default: wdataE = de.rd2;
    endcase
  end

  assign srcbE = de.ctrl.alusrc ? de.signimm : wdataE;

  always_comb begin
    case (de.ctrl.alucontrol)
      ALU_AND: aluoutE = srcaE & srcbE;
      ALU_OR:  aluoutE = srcaE | srcbE;
      ALU_ADD: aluoutE = srcaE + srcbE;
      ALU_SUB: aluoutE = srcaE - srcbE;
      ALU_SLT: aluoutE = {{(N-1){1'b0}}, $signed(srcaE) < $signed(srcbE)};
      ALU_NOR: aluoutE = ~(srcaE | srcbE);
      default: aluoutE = '0;
    endcase
  end

  assign zeroE     = (aluoutE == '0);
  assign takenE    = de.ctrl.branch && zeroE;
  assign pcbranchE = de.pcplus4 + {de.signimm[N-3:0], 2'b00};
  assign writeregE = de.ctrl.regdst ? de.rd : de.rt;

  always_ff @(posedge clk or posedge reset)
    if (reset) em <= EX_MEM_BUBBLE;
    else       em <= '{regwrite: de.ctrl.regwrite, memtoreg: de.ctrl.memtoreg,
                       memwrite: de.ctrl.memwrite, aluout: aluoutE,
                       writedata: wdataE, writereg: writeregE};

  // ---------------- MEM ----------------
  assign memwriteM  = em.memwrite;
  assign aluoutM    = em.aluout;
  assign writedataM = em.writedata;

  always_ff @(posedge clk or posedge reset)
    if (reset) mw <= MEM_WB_BUBBLE;
    else       mw <= '{regwrite: em.regwrite, memtoreg: em.memtoreg, aluout: em.aluout,
                       readdata: readdataM, writereg: em.writereg};

  // ---------------- WB ----------------
  assign resultW = mw.memtoreg ? mw.readdata : mw.aluout;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (mw.regwrite && mw.writereg != 5'd0) begin
      rf[mw.writereg] <= resultW;
    end

  hazard_unit u_hazard (
    .rsD       (rsD),
    .rtD       (rtD),
    .rsE       (de.rs),
    .rtE       (de.rt),
    .writeregM (em.writereg),
    .writeregW (mw.writereg),
    .regwriteM (em.regwrite),
    .regwriteW (mw.regwrite),
    .memtoregE (de.ctrl.memtoreg),
    .takenE    (takenE),
    .jumpD     (jumpD),
    .fwdA      (fwdA),
    .fwdB      (fwdB),
    .stallF    (stallF),
    .stallD    (stallD),
    .flushD    (flushD),
    .flushE    (flushE)
  );

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench: the bench plays decoder, instruction and data memory, and
// checks fetch order, forwarding, stalls, flushes and reset against hand values.
module tb_pipelined_datapath;
  localparam int          N   = 32;
  localparam logic [31:0] RPC = 32'h100;

  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b,
                         OP_BEQ = 6'h04, OP_J = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2a;

  logic         clk = 1'b0, reset = 1'b1;
  logic [N-1:0] pc, aluoutM, writedataM, readdataM;
  logic [31:0]  instr, instrD;
  logic         regwriteD, memtoregD, memwriteD, alusrcD, regdstD, branchD, jumpD;
  logic [3:0]   alucontrolD;
  logic         memwriteM, stallF, flushE;

  always #5 clk = ~clk;

  pipelined_datapath #(.N(N), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr), .instrD(instrD),
    .regwriteD(regwriteD), .memtoregD(memtoregD), .memwriteD(memwriteD),
    .alusrcD(alusrcD), .regdstD(regdstD), .branchD(branchD), .jumpD(jumpD),
    .alucontrolD(alucontrolD), .memwriteM(memwriteM), .aluoutM(aluoutM),
    .writedataM(writedataM), .readdataM(readdataM), .stallF(stallF), .flushE(flushE)
  );

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  assign instr     = imem[pc[9:2]];
  assign readdataM = dmem[aluoutM[9:2]];

  // External decoder model
  always_comb begin
    {regwriteD, memtoregD, memwriteD, alusrcD, regdstD, branchD, jumpD} = '0;
    alucontrolD = 4'b0010;
    case (instrD[31:26])
      OP_R: begin
        regwriteD = 1'b1; regdstD = 1'b1;
        case (instrD[5:0])
          F_ADD:   alucontrolD = 4'b0010;
          F_SUB:   alucontrolD = 4'b0110;
          F_AND:   alucontrolD = 4'b0000;
          F_OR:    alucontrolD = 4'b0001;
          F_SLT:   alucontrolD = 4'b0111;
          default: begin regwriteD = 1'b0; regdstD = 1'b0; end
        endcase
      end
      OP_ADDI: begin regwriteD = 1'b1; alusrcD = 1'b1; end
      OP_LW:   begin regwriteD = 1'b1; alusrcD = 1'b1; memtoregD = 1'b1; end
      OP_SW:   begin alusrcD = 1'b1; memwriteD = 1'b1; end
      OP_BEQ:  begin branchD = 1'b1; alucontrolD = 4'b0110; end
      OP_J:    jumpD = 1'b1;
      default: ;
    endcase
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs, rt, rd);
    return {OP_R, rs, rt, rd, 5'd0, f};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] a);
    return {OP_J, a[27:2]};
  endfunction

  logic [31:0] pc_log [64];
  logic [31:0] id_log [64];
  logic        sf_log [64];
  logic        fe_log [64];
  logic [31:0] st_addr [$];
  logic [31:0] st_data [$];
  logic [31:0] st_cyc  [$];
  int          n_stall;

  function automatic logic [31:0] qget(input logic [31:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    imem[a[9:2]] = w;
  endtask

  task automatic prep();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin imem[i] = '0; dmem[i] = '0; end
    st_addr.delete(); st_data.delete(); st_cyc.delete();
    n_stall = 0;
  endtask

  task automatic go();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Sample once per cycle just after the falling edge; stores land in dmem here.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      #1;
      pc_log[c] = pc; id_log[c] = instrD; sf_log[c] = stallF; fe_log[c] = flushE;
      if (stallF) n_stall++;
      if (memwriteM) begin
        dmem[aluoutM[9:2]] = writedataM;
        st_addr.push_back(aluoutM); st_data.push_back(writedataM); st_cyc.push_back(c);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    // ---- reset state and forwarding program ----
    prep();
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_instrD", instrD, 32'h0);
    chk("rst_memwriteM", {31'd0, memwriteM}, 32'h0);
    chk("rst_aluoutM", aluoutM, 32'h0);
    chk("rst_writedataM", writedataM, 32'h0);
    chk("rst_stallF", {31'd0, stallF}, 32'h0);
    chk("rst_flushE", {31'd0, flushE}, 32'h0);
    put(32'h100, enc_i(OP_ADDI, 0, 1, 16'd5));
    put(32'h104, enc_r(F_ADD, 1, 1, 2));
    put(32'h108, enc_i(OP_SW, 0, 2, 16'd0));
    put(32'h110, enc_r(F_SUB, 2, 1, 5));
    put(32'h118, enc_i(OP_SW, 0, 5, 16'd4));
    put(32'h11C, enc_r(F_SLT, 1, 2, 6));
    put(32'h120, enc_i(OP_SW, 0, 6, 16'd8));
    put(32'h124, enc_i(OP_ADDI, 0, 7, 16'd1));
    put(32'h128, enc_i(OP_ADDI, 7, 7, 16'd2));
    put(32'h12C, enc_r(F_ADD, 7, 7, 8));
    put(32'h130, enc_i(OP_SW, 0, 8, 16'd12));
    go();
    run(18);
    chk("fetch_pc0", pc_log[0], 32'h100);
    chk("fetch_pc1", pc_log[1], 32'h104);
    chk("fetch_pc2", pc_log[2], 32'h108);
    chk("first_instrD", id_log[0], 32'h0);
    chk("second_instrD", id_log[1], enc_i(OP_ADDI, 0, 1, 16'd5));
    chk("fwd_nstores", st_addr.size(), 32'd4);
    chk("fwd_first_store_cyc", qget(st_cyc, 0), 32'd5);
    chk("fwd_mem_add", qget(st_data, 0), 32'd10);
    chk("fwd_wb_sub", qget(st_data, 1), 32'd5);
    chk("fwd_slt", qget(st_data, 2), 32'd1);
    chk("fwd_mem_over_wb", qget(st_data, 3), 32'd6);
    chk("fwd_addr3", qget(st_addr, 3), 32'd12);
    chk("fwd_no_stall", n_stall, 32'd0);

    // ---- load-use stall ----
    prep();
    put(32'h100, enc_i(OP_LW, 0, 3, 16'd0));
    put(32'h104, enc_r(F_ADD, 3, 3, 4));
    put(32'h108, enc_i(OP_SW, 0, 4, 16'd16));
    dmem[0] = 32'h7;
    go();
    run(10);
    chk("lu_stallF_c1", {31'd0, sf_log[1]}, 32'h0);
    chk("lu_stallF_c2", {31'd0, sf_log[2]}, 32'h1);
    chk("lu_flushE_c2", {31'd0, fe_log[2]}, 32'h1);
    chk("lu_stall_count", n_stall, 32'd1);
    chk("lu_pc_held", pc_log[3], 32'h108);
    chk("lu_pc_resume", pc_log[4], 32'h10C);
    chk("lu_result", qget(st_data, 0), 32'h0E);
    chk("lu_addr", qget(st_addr, 0), 32'd16);

    // ---- taken beq flushes two slots ----
    prep();
    put(32'h100, enc_i(OP_BEQ, 0, 0, 16'd2));
    put(32'h104, enc_i(OP_ADDI, 0, 9, 16'h55));
    put(32'h108, enc_i(OP_SW, 0, 0, 16'd20));
    put(32'h10C, enc_i(OP_SW, 0, 9, 16'd24));
    go();
    run(9);
    chk("br_flushE", {31'd0, fe_log[2]}, 32'h1);
    chk("br_stallF", {31'd0, sf_log[2]}, 32'h0);
    chk("br_target_pc", pc_log[3], 32'h10C);
    chk("br_bubble_instrD", id_log[3], 32'h0);
    chk("br_next_instrD", id_log[4], enc_i(OP_SW, 0, 9, 16'd24));
    chk("br_nstores", st_addr.size(), 32'd1);
    chk("br_store_addr", qget(st_addr, 0), 32'd24);
    chk("br_no_regwrite", qget(st_data, 0), 32'd0);

    // ---- jump flushes one slot ----
    prep();
    put(32'h100, enc_j(32'h40));
    put(32'h104, enc_i(OP_ADDI, 0, 10, 16'h33));
    put(32'h040, enc_i(OP_SW, 0, 10, 16'd28));
    go();
    run(8);
    chk("j_target_pc", pc_log[2], 32'h40);
    chk("j_bubble_instrD", id_log[2], 32'h0);
    chk("j_next_instrD", id_log[3], enc_i(OP_SW, 0, 10, 16'd28));
    chk("j_store_addr", qget(st_addr, 0), 32'd28);
    chk("j_no_regwrite", qget(st_data, 0), 32'd0);

    // ---- branch in EX beats jump in ID ----
    prep();
    put(32'h100, enc_i(OP_BEQ, 0, 0, 16'd3));
    put(32'h104, enc_j(32'h40));
    go();
    run(5);
    chk("bj_flushE", {31'd0, fe_log[2]}, 32'h1);
    chk("bj_stallF", {31'd0, sf_log[2]}, 32'h0);
    chk("bj_pc", pc_log[3], 32'h110);

    // ---- async reset with a store in EX ----
    prep();
    put(32'h100, enc_i(OP_ADDI, 0, 1, 16'd9));
    put(32'h104, enc_i(OP_SW, 0, 1, 16'd4));
    go();
    run(3);
    #1;
    chk("ar_pc_before", pc, 32'h10C);
    chk("ar_memwrite_before", {31'd0, memwriteM}, 32'h0);
    reset = 1'b1;
    #1;
    chk("ar_pc_async", pc, RPC);
    chk("ar_instrD", instrD, 32'h0);
    @(negedge clk);
    run(3);
    chk("ar_no_store", st_addr.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
